pc_step_fetch: RTL and testbench

Single-step instruction fetch stage directly downstream of the debug/reset button debouncer. Takes each new PC value the debouncer issues (with a one-cycle strobe) and reads the instruction at that address from a synchronous instruction ROM. Holds the fetched instruction for the decoder under a valid/ready handshake. Returns the current PC to the debouncer's pc input, closing the step loop.

---
 rtl/pc_step_fetch.sv | 133 +++++++++++++
 tb/tb_pc_step_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_step_fetch.sv
// Single-step fetch stage: turns debouncer PC strobes into one ROM read each and
// holds the result for the decoder. Optional `AUTO_RUN_EN adds a run input that
// auto-increments the PC after each accepted instruction.
module pc_step_fetch #(
  parameter int          PC_W     = 8,
  parameter int          INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               resetpin,
`ifdef AUTO_RUN_EN
  input  logic               run,
`endif
  input  logic [PC_W-1:0]    pc_in,
  input  logic               pc_in_stb,
  output logic               mem_rd_en,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [PC_W-1:0]    pc_out,
  output logic               busy,
  output logic               overrun,
  output logic [CNT_W-1:0]   fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, ipc_q, ipc_d, pend_pc_q, pend_pc_d;
  logic               pend_vld_q, pend_vld_d, vld_q, vld_d, ovr_q, ovr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hs, run_i;

`ifdef AUTO_RUN_EN
  assign run_i = run;
`else
  assign run_i = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ipc_d      = ipc_q;
    instr_d    = instr_q;
    vld_d      = vld_q;
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;
    ovr_d      = ovr_q;
    cnt_d      = cnt_q;
    hs         = vld_q & instr_ready;

    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          pc_d       = pend_pc_q;
          pend_vld_d = 1'b0;
          state_d    = FETCH;
        end else if (pc_in_stb) begin
          pc_d    = pc_in;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        instr_d = mem_rdata;
        ipc_d   = pc_q;
        vld_d   = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (hs) begin
          vld_d = 1'b0;
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          // A queued or same-cycle strobe outranks auto-increment.
          if (run_i && !pend_vld_q && !pc_in_stb) begin
            pc_d    = pc_q + PC_W'(1);
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes not consumed directly from IDLE land in the one-entry pending slot.
    if (pc_in_stb && (state_q != IDLE || pend_vld_q)) begin
      if (pend_vld_q && state_q != IDLE) ovr_d = 1'b1;
      pend_vld_d = 1'b1;
      pend_pc_d  = pc_in;
    end
  end

  always_ff @(posedge clk or posedge resetpin) begin
    if (resetpin) begin
      state_q    <= IDLE;
      pc_q       <= PC_W'(RESET_PC);
      ipc_q      <= '0;
      instr_q    <= '0;
      vld_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
      ovr_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ipc_q      <= ipc_d;
      instr_q    <= instr_d;
      vld_q      <= vld_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
      ovr_q      <= ovr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_rd_en   = (state_q == FETCH);
  assign mem_addr    = mem_rd_en ? pc_q : '0;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = vld_q;
  assign pc_out      = pc_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = ovr_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_step_fetch.sv
// Scoreboard bench for pc_step_fetch: stimulus pushes expected fetch addresses,
// a negedge monitor checks every presented instruction against a ROM model.
module tb_pc_step_fetch;
  localparam int PC_W = 8, INSTR_W = 16, CNT_W = 4;

  logic               clk = 1'b0;
  logic               resetpin;
  logic [PC_W-1:0]    pc_in;
  logic               pc_in_stb;
  logic               mem_rd_en;
  logic [PC_W-1:0]    mem_addr;
  logic [INSTR_W-1:0] mem_rdata = '0;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [PC_W-1:0]    pc_out;
  logic               busy;
  logic               overrun;
  logic [CNT_W-1:0]   fetch_count;
`ifdef AUTO_RUN_EN
  logic               run;
`endif

  pc_step_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetpin(resetpin),
`ifdef AUTO_RUN_EN
    .run(run),
`endif
    .pc_in(pc_in), .pc_in_stb(pc_in_stb),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_out(pc_out), .busy(busy), .overrun(overrun), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model: data one cycle after the read enable.
  logic [INSTR_W-1:0] rom [0:255];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= rom[mem_addr];

  logic [PC_W-1:0] exp_q[$];
  logic [PC_W-1:0] ext [3];
  int errors = 0, checks = 0;
  int m_cnt = 0;
  bit m_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!instr_valid && n < 20) begin step(); n++; end
    ok = instr_valid;
    if (!ok) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  function automatic int sat_inc(input int c);
    return (c >= 15) ? 15 : c + 1;
  endfunction

  // Monitor: every presented instruction must match the oldest expected fetch.
  always @(negedge clk) begin
    if (!resetpin && instr_valid) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        chk("instr", instr, rom[exp_q[0]]);
        chk("instr_pc", instr_pc, exp_q[0]);
        chk("pc_out_hold", pc_out, exp_q[0]);
        if (instr_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One step: strobe a, then k extra strobes while busy; accept with rdly wait.
  task automatic txn(input logic [PC_W-1:0] a, input int k, input int rdly);
    int nexp;
    bit ok;
    pc_in = a; pc_in_stb = 1'b1; exp_q.push_back(a); step();
    for (int i = 0; i < k; i++) begin pc_in = ext[i]; step(); end
    pc_in_stb = 1'b0;
    nexp = 1;
    if (k > 0) begin exp_q.push_back(ext[k-1]); nexp = 2; end
    if (k > 1) m_ovr = 1'b1;
    for (int j = 0; j < nexp; j++) begin
      wait_valid(ok);
      if (ok) begin
        repeat (rdly) step();
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        m_cnt = sat_inc(m_cnt);
        chk("valid_drop", instr_valid, 32'd0);
        chk("fetch_count", fetch_count, m_cnt);
      end
    end
    chk("overrun", overrun, m_ovr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = INSTR_W'($urandom);
    rom[5] = 16'hA5A5;
    resetpin = 1'b1; pc_in = '0; pc_in_stb = 1'b0; instr_ready = 1'b0;
`ifdef AUTO_RUN_EN
    run = 1'b0;
`endif
    #12;
    chk("rst_valid", instr_valid, 0); chk("rst_pc", pc_out, 0);
    chk("rst_instr", instr, 0);       chk("rst_ipc", instr_pc, 0);
    chk("rst_rden", mem_rd_en, 0);    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);         chk("rst_ovr", overrun, 0);
    chk("rst_cnt", fetch_count, 0);
    step(); resetpin = 1'b0; step();

    // Latency and hold stability.
    pc_in = 8'h05; pc_in_stb = 1'b1; exp_q.push_back(8'h05); step(); pc_in_stb = 1'b0;
    chk("n1_rden", mem_rd_en, 1); chk("n1_addr", mem_addr, 8'h05); chk("n1_pc", pc_out, 8'h05);
    step();
    chk("n2_rden", mem_rd_en, 0); chk("n2_valid", instr_valid, 0);
    step();
    chk("n3_valid", instr_valid, 1); chk("n3_instr", instr, 16'hA5A5);
    repeat (10) step();
    chk("hold_valid", instr_valid, 1);
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    m_cnt = 1;
    chk("hs_valid", instr_valid, 0); chk("hs_cnt", fetch_count, 1);
    step();

    // Latest-wins pending with overrun.
    ext[0] = 8'h10; ext[1] = 8'h20; ext[2] = 8'h30;
    txn(8'h07, 3, 2);
    step();

    // Reset during WAIT discards the read.
    pc_in = 8'h44; pc_in_stb = 1'b1; exp_q.push_back(8'h44); step(); pc_in_stb = 1'b0;
    step();
    #2 resetpin = 1'b1; #1;
    chk("mid_rst_valid", instr_valid, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pc", pc_out, 0);         chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_cnt", fetch_count, 0);   chk("mid_rst_rden", mem_rd_en, 0);
    exp_q.delete(); m_cnt = 0; m_ovr = 1'b0;
    step(); step(); resetpin = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); chk("post_rst_idle", {busy, instr_valid}, 0); end

    // Randomized steps; enough handshakes to saturate the 4-bit counter.
    for (int t = 0; t < 28; t++) begin
      for (int i = 0; i < 3; i++) ext[i] = PC_W'($urandom);
      txn(PC_W'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 2)) step();
    end

`ifdef AUTO_RUN_EN
    begin
      int n = 0;
      run = 1'b1; instr_ready = 1'b1;
      pc_in = 8'hFE; pc_in_stb = 1'b1;
      exp_q.push_back(8'hFE); exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
      step(); pc_in_stb = 1'b0;
      while (exp_q.size() > 0 && n < 60) begin
        if (exp_q.size() == 1) run = 1'b0;
        step(); n++;
      end
      chk("auto_drain", exp_q.size(), 0);
      instr_ready = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt = sat_inc(m_cnt);
      step();
      chk("auto_pc", pc_out, 8'h01); chk("auto_busy", busy, 0);
      chk("auto_cnt", fetch_count, m_cnt);
    end
`endif

    repeat (3) step();
    chk("final_cnt", fetch_count, 15);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
